// File: rtl/tcdm_bank_arb_init.sv
// tcdm_bank_arb_init: shares one latency-1 SRAM bank between two TCDM
// requesters (A, B) with round-robin arbitration. It routes each response
// back to the port that issued the request. After reset, or on init_i, it
// runs a sweep that writes INIT_VALUE to every word of the bank.
module tcdm_bank_arb_init #(
  parameter int unsigned BANK_SIZE  = 256,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
  localparam int unsigned WA = $clog2(BANK_SIZE),
  localparam int unsigned AW = WA + 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          init_i,
  output logic          init_busy_o,
  output logic          init_done_o,
  input  logic          a_req_i,
  input  logic          a_wen_i,
  input  logic [AW-1:0] a_add_i,
  input  logic [31:0]   a_data_i,
  input  logic [3:0]    a_be_i,
  output logic          a_gnt_o,
  output logic          a_r_valid_o,
  output logic [31:0]   a_r_data_o,
  input  logic          b_req_i,
  input  logic          b_wen_i,
  input  logic [AW-1:0] b_add_i,
  input  logic [31:0]   b_data_i,
  input  logic [3:0]    b_be_i,
  output logic          b_gnt_o,
  output logic          b_r_valid_o,
  output logic [31:0]   b_r_data_o,
  output logic          bank_req_o,
  output logic          bank_we_o,
  output logic [WA-1:0] bank_add_o,
  output logic [31:0]   bank_wdata_o,
  output logic [3:0]    bank_be_o,
  input  logic [31:0]   bank_rdata_i
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam logic [WA-1:0] LAST_WORD = WA'(BANK_SIZE - 1);
  localparam logic [WA-1:0] ZERO_WORD = {WA{1'b0}};

  state_e        state_r, state_s;
  logic [WA-1:0] cnt_r, cnt_s;
  // Round-robin pointer: 1'b0 favours A, 1'b1 favours B on contention.
  logic          rr_r, rr_s;
  logic          done_r, done_s;
  logic          a_rvalid_r, b_rvalid_r;
  logic          a_gnt_s, b_gnt_s;

  // Round-robin grant decision; grants are only possible in IDLE, out of reset.
  always_comb begin
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    if (!rst_i && (state_r == ST_IDLE)) begin
      if (a_req_i && b_req_i) begin
        if (rr_r == 1'b0) begin
          a_gnt_s = 1'b1;
        end else begin
          b_gnt_s = 1'b1;
        end
      end else begin
        a_gnt_s = a_req_i;
        b_gnt_s = b_req_i;
      end
    end else begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
    end
  end

  // Next state: sweep counter progression, init restarts and pointer rotation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rr_s    = rr_r;
    done_s  = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_i) begin
          // Restart the sweep; the aborted sweep produces no done pulse.
          cnt_s = ZERO_WORD;
        end else if (cnt_r == LAST_WORD) begin
          state_s = ST_IDLE;
          cnt_s   = ZERO_WORD;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + WA'(1);
        end
      end
      ST_IDLE: begin
        if (a_gnt_s) begin
          rr_s = 1'b1;
        end else if (b_gnt_s) begin
          rr_s = 1'b0;
        end else begin
          rr_s = rr_r;
        end
        // The current request is still served; the sweep starts next cycle.
        if (init_i) begin
          state_s = ST_INIT;
          cnt_s   = ZERO_WORD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = ZERO_WORD;
      end
    endcase
  end

  // Bank port mux: the sweep writer in INIT, otherwise the granted requester.
  always_comb begin
    bank_req_o   = 1'b0;
    bank_we_o    = 1'b0;
    bank_add_o   = ZERO_WORD;
    bank_wdata_o = 32'h0000_0000;
    bank_be_o    = 4'h0;
    if (rst_i) begin
      bank_req_o = 1'b0;
    end else if (state_r == ST_INIT) begin
      bank_req_o   = 1'b1;
      bank_we_o    = 1'b1;
      bank_add_o   = cnt_r;
      bank_wdata_o = INIT_VALUE;
      bank_be_o    = 4'hF;
    end else if (a_gnt_s) begin
      bank_req_o   = 1'b1;
      bank_we_o    = ~a_wen_i;
      bank_add_o   = a_add_i[AW-1:2];
      bank_wdata_o = a_data_i;
      bank_be_o    = a_be_i;
    end else if (b_gnt_s) begin
      bank_req_o   = 1'b1;
      bank_we_o    = ~b_wen_i;
      bank_add_o   = b_add_i[AW-1:2];
      bank_wdata_o = b_data_i;
      bank_be_o    = b_be_i;
    end else begin
      bank_req_o = 1'b0;
    end
  end

  // State, counter, pointer and response-owner registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_INIT;
      cnt_r      <= ZERO_WORD;
      rr_r       <= 1'b0;
      done_r     <= 1'b0;
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      rr_r       <= rr_s;
      done_r     <= done_s;
      a_rvalid_r <= a_gnt_s;
      b_rvalid_r <= b_gnt_s;
    end
  end

  // Responses and the done pulse are masked while reset is held, so a reset
  // that arrives just after a grant drops the pending response.
  assign a_gnt_o     = a_gnt_s;
  assign b_gnt_o     = b_gnt_s;
  assign a_r_valid_o = a_rvalid_r & ~rst_i;
  assign b_r_valid_o = b_rvalid_r & ~rst_i;
  assign a_r_data_o  = bank_rdata_i;
  assign b_r_data_o  = bank_rdata_i;
  assign init_done_o = done_r & ~rst_i;
  assign init_busy_o = rst_i | (state_r == ST_INIT);

endmodule

// File: tb/tb_tcdm_bank_arb_init.sv
// Testbench for tcdm_bank_arb_init. It runs directed scenarios followed by
// randomized traffic. Each cycle the DUT outputs are compared with a
// transaction-level reference model: a golden word array, a preferred-port
// variable and one expected-response slot.
module tb_tcdm_bank_arb_init;

  localparam int unsigned BANK_SIZE = 256;
  localparam int unsigned WA = 8;
  localparam int unsigned AW = 10;
  localparam logic [31:0] INIT_VALUE = 32'h0000_0000;

  logic          clk;
  logic          rst;
  logic          init;
  logic          init_busy, init_done;
  logic          a_req, a_wen, a_gnt, a_r_valid;
  logic [AW-1:0] a_add;
  logic [31:0]   a_data, a_r_data;
  logic [3:0]    a_be;
  logic          b_req, b_wen, b_gnt, b_r_valid;
  logic [AW-1:0] b_add;
  logic [31:0]   b_data, b_r_data;
  logic [3:0]    b_be;
  logic          bank_req, bank_we;
  logic [WA-1:0] bank_add;
  logic [31:0]   bank_wdata, bank_rdata;
  logic [3:0]    bank_be;

  tcdm_bank_arb_init #(.BANK_SIZE(BANK_SIZE), .INIT_VALUE(INIT_VALUE)) dut (
    .clk_i(clk), .rst_i(rst), .init_i(init),
    .init_busy_o(init_busy), .init_done_o(init_done),
    .a_req_i(a_req), .a_wen_i(a_wen), .a_add_i(a_add), .a_data_i(a_data),
    .a_be_i(a_be), .a_gnt_o(a_gnt), .a_r_valid_o(a_r_valid), .a_r_data_o(a_r_data),
    .b_req_i(b_req), .b_wen_i(b_wen), .b_add_i(b_add), .b_data_i(b_data),
    .b_be_i(b_be), .b_gnt_o(b_gnt), .b_r_valid_o(b_r_valid), .b_r_data_o(b_r_data),
    .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_add_o(bank_add),
    .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 SRAM bank stub with byte enables.
  logic [31:0] sram [BANK_SIZE];
  always @(posedge clk) begin
    if (bank_req) begin
      if (bank_we) begin
        for (int i = 0; i < 4; i++)
          if (bank_be[i]) sram[bank_add][8*i +: 8] <= bank_wdata[8*i +: 8];
      end else begin
        bank_rdata <= sram[bank_add];
      end
    end
  end

  // Reference model state.
  int          errors, checks;
  bit          m_busy, m_done;
  int          m_idx, m_pref;
  bit          p_valid, p_read;
  int          p_port;
  logic [31:0] p_data;
  logic [31:0] gold [BANK_SIZE];
  int          obs_busy, obs_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: the inputs are already driven. Check outputs mid-cycle,
  // then advance the model at the clock edge.
  task automatic cycle();
    int          win;
    logic        w_wen;
    logic [AW-1:0] w_add;
    logic [31:0] w_data;
    logic [3:0]  w_be;
    int          widx;
    #1;
    if (init_busy) obs_busy++;
    if (init_done) obs_done++;
    win = -1;
    if (!rst && !m_busy) begin
      if (a_req && b_req) win = m_pref;
      else if (a_req) win = 0;
      else if (b_req) win = 1;
    end
    if (win == 1) begin
      w_wen = b_wen; w_add = b_add; w_data = b_data; w_be = b_be;
    end else begin
      w_wen = a_wen; w_add = a_add; w_data = a_data; w_be = a_be;
    end
    chk("a_gnt", a_gnt, win == 0);
    chk("b_gnt", b_gnt, win == 1);
    chk("bank_req", bank_req, !rst && (m_busy || win >= 0));
    chk("init_busy", init_busy, rst || m_busy);
    chk("init_done", init_done, !rst && m_done);
    chk("a_r_valid", a_r_valid, !rst && p_valid && p_port == 0);
    chk("b_r_valid", b_r_valid, !rst && p_valid && p_port == 1);
    if (!rst && p_valid && p_read) begin
      if (p_port == 0) chk("a_r_data", a_r_data, p_data);
      else chk("b_r_data", b_r_data, p_data);
    end
    if (!rst && m_busy) begin
      chk("sweep_we", bank_we, 1'b1);
      chk("sweep_be", bank_be, 4'hF);
      chk("sweep_wdata", bank_wdata, INIT_VALUE);
      chk("sweep_add", bank_add, m_idx);
    end else if (win >= 0) begin
      chk("bank_we", bank_we, !w_wen);
      chk("bank_add", bank_add, w_add[AW-1:2]);
      if (!w_wen) begin
        chk("bank_wdata", bank_wdata, w_data);
        chk("bank_be", bank_be, w_be);
      end
    end
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b1; m_idx = 0; m_pref = 0; m_done = 1'b0; p_valid = 1'b0;
    end else if (m_busy) begin
      gold[m_idx] = INIT_VALUE;
      m_done = 1'b0;
      p_valid = 1'b0;
      if (init) m_idx = 0;
      else if (m_idx == BANK_SIZE - 1) begin
        m_busy = 1'b0; m_idx = 0; m_done = 1'b1;
      end else m_idx++;
    end else begin
      m_done = 1'b0;
      p_valid = (win >= 0);
      if (win >= 0) begin
        widx = int'(w_add[AW-1:2]);
        p_port = win;
        p_read = w_wen;
        if (w_wen) p_data = gold[widx];
        else
          for (int i = 0; i < 4; i++)
            if (w_be[i]) gold[widx][8*i +: 8] = w_data[8*i +: 8];
        m_pref = 1 - win;
      end
      if (init) begin
        m_busy = 1'b1; m_idx = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_a(input logic req, input logic wen, input logic [AW-1:0] add,
                       input logic [31:0] data, input logic [3:0] be);
    a_req = req; a_wen = wen; a_add = add; a_data = data; a_be = be;
  endtask

  task automatic set_b(input logic req, input logic wen, input logic [AW-1:0] add,
                       input logic [31:0] data, input logic [3:0] be);
    b_req = req; b_wen = wen; b_add = add; b_data = data; b_be = be;
  endtask

  initial begin
    bit restarted;
    logic [AW-1:0] ra;
    errors = 0; checks = 0; obs_busy = 0; obs_done = 0;
    m_busy = 1'b1; m_idx = 0; m_pref = 0; m_done = 1'b0; p_valid = 1'b0;
    p_read = 1'b0; p_port = 0; p_data = 32'h0;
    rst = 1'b1; init = 1'b0;
    set_a(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);
    set_b(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);

    // Reset held for two cycles.
    cycle(); cycle();
    rst = 1'b0;

    // Power-up sweep, with A requesting throughout; the grant comes on the done cycle.
    obs_busy = 0; obs_done = 0;
    set_a(1'b1, 1'b1, 10'h000, 32'h0, 4'hF);
    for (int i = 0; i < 257; i++) cycle();
    chk("sweep_busy_cycles", obs_busy, 256);
    chk("sweep_done_pulses", obs_done, 1);

    // Write, read back and read an untouched word.
    set_a(1'b1, 1'b0, 10'h010, 32'hDEAD_BEEF, 4'hF); cycle();
    set_a(1'b1, 1'b1, 10'h010, 32'h0, 4'hF); cycle();
    set_a(1'b1, 1'b1, 10'h014, 32'h0, 4'hF); cycle();
    set_a(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 10'h040, 32'h1234_5678, 4'hF); cycle();

    // Contention for six cycles: grants alternate A, B, A, B, A, B.
    set_a(1'b1, 1'b1, 10'h010, 32'h0, 4'hF);
    set_b(1'b1, 1'b1, 10'h040, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) cycle();
    set_a(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);
    set_b(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);
    cycle();

    // Partial byte-enable write to a zeroed word, then read it back.
    set_a(1'b1, 1'b0, 10'h020, 32'h0000_AB00, 4'b0010); cycle();
    set_a(1'b1, 1'b1, 10'h020, 32'h0, 4'hF); cycle();
    set_a(1'b0, 1'b1, 10'h000, 32'h0, 4'h0); cycle();

    // Sweep restarted at word 100: 101 + 256 busy cycles and one done pulse.
    init = 1'b1; cycle();
    obs_busy = 0; obs_done = 0; restarted = 1'b0;
    for (int i = 0; i < 400; i++) begin
      init = m_busy && (m_idx == 100) && !restarted;
      if (init) restarted = 1'b1;
      cycle();
    end
    init = 1'b0;
    chk("restart_busy_cycles", obs_busy, 357);
    chk("restart_done_pulses", obs_done, 1);

    // Reset directly after a B read grant: the response is dropped and the
    // pointer returns to A.
    set_b(1'b1, 1'b1, 10'h020, 32'h0, 4'hF); cycle();
    set_b(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);
    rst = 1'b1; cycle();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) cycle();
    set_a(1'b1, 1'b1, 10'h004, 32'h0, 4'hF);
    set_b(1'b1, 1'b1, 10'h008, 32'h0, 4'hF);
    cycle(); cycle();
    set_a(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);
    set_b(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);
    cycle();

    // Randomized traffic on a small address window, with occasional init and reset.
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      init = ($urandom_range(0, 149) == 0);
      ra = {AW{1'b0}}; ra[5:2] = 4'($urandom); ra[1:0] = 2'($urandom);
      set_a($urandom_range(0, 2) != 0, 1'($urandom), ra, $urandom, 4'($urandom));
      ra = {AW{1'b0}}; ra[5:2] = 4'($urandom); ra[1:0] = 2'($urandom);
      set_b($urandom_range(0, 2) != 0, 1'($urandom), ra, $urandom, 4'($urandom));
      cycle();
    end
    rst = 1'b0; init = 1'b0;
    set_a(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);
    set_b(1'b0, 1'b1, 10'h000, 32'h0, 4'h0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_arb_init.md
# tcdm_bank_arb_init

Single-bank TCDM access controller: shares one 32-bit, latency-1 SRAM bank port between two requesters (A, B) with round-robin arbitration, routes read responses back to the owner, and runs a hardware initialization sweep that writes INIT_VALUE to every word after reset or on request. Sits between the cluster interconnect/DMA ports and one `tc_sram`-style bank (gnt tied high on the bank side). During a sweep, requesters are stalled.

## Interface
- BANK_SIZE, 256, words in the bank; power of two, ≥ 4; AW = $clog2(BANK_SIZE)+2 (byte address width)
- INIT_VALUE, 32'h0000_0000, word written by the init sweep
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- init_i  in  1  start (or restart) an init sweep; sampled in any state
- init_busy_o  out  1  high while a sweep is in progress
- init_done_o  out  1  one-cycle pulse when a sweep completes
- a_req_i / b_req_i  in  1  request
- a_wen_i / b_wen_i  in  1  1 = read, 0 = write
- a_add_i / b_add_i  in  AW  byte address; bits [AW-1:2] select the word, [1:0] ignored
- a_data_i / b_data_i  in  32  write data
- a_be_i / b_be_i  in  4  byte enables (writes)
- a_gnt_o / b_gnt_o  out  1  grant, combinational from req in the same cycle
- a_r_valid_o / b_r_valid_o  out  1  response valid, one cycle after the grant
- a_r_data_o / b_r_data_o  out  32  read data; equals bank_rdata_i; meaningful only with r_valid and a read
- bank_req_o  out  1  bank request
- bank_we_o  out  1  bank write enable (active-high)
- bank_add_o  out  $clog2(BANK_SIZE)  bank word address
- bank_wdata_o  out  32  bank write data
- bank_be_o  out  4  bank byte enables
- bank_rdata_i  in  32  bank read data, valid one cycle after a read request

## Operation
- States: INIT, IDLE. Reset forces INIT with sweep counter = 0 and RR pointer = A.
- INIT: each cycle bank_req_o=1, bank_we_o=1, bank_be_o=4'hF, bank_wdata_o=INIT_VALUE, bank_add_o=counter; counter++. Both gnts are 0. After the write at BANK_SIZE-1 → IDLE, counter → 0.
- init_i=1 in IDLE → INIT next cycle, counter=0. init_i=1 during INIT → counter restarts at 0 next cycle (sweep restarts; no done pulse for the aborted sweep).
- IDLE arbitration: only one req → grant it. Both → grant the port the RR pointer selects. After any grant to X, pointer ← other(X). No req → bank_req_o=0, pointer unchanged.
- Granted port drives the bank: bank_we_o = ~wen, bank_add_o = add[AW-1:2], wdata/be passed through (be forced 4'hF only in INIT).
- Response: owner register records the granted port; next cycle that port's r_valid_o=1 (reads and writes alike). r_data_o of both ports is bank_rdata_i unconditionally.
- init_i in the same cycle as a request in IDLE: request is granted and served; INIT starts the next cycle. A response in flight when entering INIT is still delivered.
- A port that holds req while not granted keeps its request stable (TCDM protocol); block does not buffer requests.

## Timing
- While rst_i=1 and in the first cycle after release, outputs: gnts 0, r_valids 0, init_done_o 0, init_busy_o 1, bank_req_o 0 during reset. First post-reset cycle writes word 0.
- Sweep length: exactly BANK_SIZE cycles of bank writes; init_busy_o=1 in each; init_done_o=1 for one cycle, the first IDLE cycle, with init_busy_o=0 in that cycle; grants possible in that same cycle.
- Grant → r_valid: 1 cycle. Back-to-back grants to either port every cycle; full throughput 1 access/cycle.
- rst_i mid-transaction: pending r_valid dropped, state → INIT, counter 0, pointer A.

## Test plan
- Reset release, BANK_SIZE=256 → 256 consecutive writes addr 0..255 of INIT_VALUE, be=F; init_busy_o high 256 cycles; init_done_o pulses on cycle 257; a_gnt_o 0 throughout sweep.
- IDLE, A write 0xDEADBEEF at byte addr 0x10 be=F, then A read 0x10 → gnt same cycle, r_valid next cycle, a_r_data_o=0xDEADBEEF; unwritten addr 0x14 reads INIT_VALUE.
- A and B request every cycle for 6 cycles → grants A,B,A,B,A,B; each r_valid on the correct port one cycle later, never both.
- A write be=4'b0010 data 0x0000AB00 to a zeroed word, read back → 0x0000AB00; bank_be_o=4'b0010 on the write.
- init_i pulsed at sweep address 100 → counter restarts at 0, total busy = 101+256 cycles, single init_done_o pulse.
- rst_i for 1 cycle immediately after a B read grant → no b_r_valid_o, sweep restarts at address 0, next contended grant goes to A.
